// File: rtl/noc_pkg.sv
// Shared flit layout, field offsets and FSM state encodings for the local network interface.
package noc_pkg;

    localparam int COORD_W  = 4;
    localparam int DATA_W   = 23;

    localparam int DST_X_HI = 38;
    localparam int DST_X_LO = 35;
    localparam int DST_Y_HI = 34;
    localparam int DST_Y_LO = 31;
    localparam int SRC_X_HI = 30;
    localparam int SRC_X_LO = 27;
    localparam int SRC_Y_HI = 26;
    localparam int SRC_Y_LO = 23;
    localparam int DATA_HI  = 22;
    localparam int DATA_LO  = 0;

    typedef struct packed {
        logic [COORD_W-1:0] dst_x;
        logic [COORD_W-1:0] dst_y;
        logic [COORD_W-1:0] src_x;
        logic [COORD_W-1:0] src_y;
        logic [DATA_W-1:0]  data;
    } flit_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_SETUP,
        T_REQ,
        T_REL
    } tx_state_e;

    typedef enum logic {
        R_IDLE,
        R_ACK
    } rx_state_e;

endpackage

// File: rtl/noc_sync_fifo.sv
// First-word fall-through synchronous FIFO; one write port, one read port, power-of-2 depth.
module noc_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wr_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so push while full is legal then.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/noc_local_ni.sv
// Local network interface: PE valid/ready on one side, router local port over 4-phase bundled data on the other.
module noc_local_ni
    import noc_pkg::*;
#(
    parameter int         WIDTH    = 39,
    parameter logic [3:0] X_LOCAL  = 4'b0000,
    parameter logic [3:0] Y_LOCAL  = 4'b0001,
    parameter int         TX_DEPTH = 4,
    parameter int         RX_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_valid,
    output logic             tx_ready,
    input  logic [3:0]       tx_dst_x,
    input  logic [3:0]       tx_dst_y,
    input  logic [22:0]      tx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic [3:0]       rx_src_x,
    output logic [3:0]       rx_src_y,
    output logic [22:0]      rx_data,
    output logic             li_req,
    output logic [WIDTH-1:0] li_data,
    input  logic             li_ack,
    input  logic             lo_req,
    input  logic [WIDTH-1:0] lo_data,
    output logic             lo_ack,
    output logic             err_self,
    output logic             err_misrt
);

    localparam int RX_W = SRC_X_HI + 1;

    logic             running;
    logic             ack_m, ack_s, req_m, req_s;
    flit_t            tx_flit;
    logic             tx_fire, tx_self, tx_push, tx_pop, tx_full, tx_empty;
    logic [WIDTH-1:0] tx_head;
    logic             rx_push, rx_pop, rx_full, rx_empty;
    logic [RX_W-1:0]  rx_head;
    tx_state_e        tx_state, tx_next;
    rx_state_e        rx_state, rx_next;
    logic             li_load, li_req_d, lo_sample, lo_match, lo_ack_d;

    // Two-flop synchronizers for the asynchronous handshake inputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            running <= 1'b0;
            ack_m   <= 1'b0;
            ack_s   <= 1'b0;
            req_m   <= 1'b0;
            req_s   <= 1'b0;
        end else begin
            running <= 1'b1;
            ack_m   <= li_ack;
            ack_s   <= ack_m;
            req_m   <= lo_req;
            req_s   <= req_m;
        end
    end

    assign tx_ready = running && !tx_full;
    assign tx_fire  = tx_valid && tx_ready;
    assign tx_self  = (tx_dst_x == X_LOCAL) && (tx_dst_y == Y_LOCAL);
    assign tx_push  = tx_fire && !tx_self;
    assign tx_flit  = '{dst_x: tx_dst_x, dst_y: tx_dst_y, src_x: X_LOCAL, src_y: Y_LOCAL, data: tx_data};

    noc_sync_fifo #(.W(WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_push),
        .wr_data (tx_flit),
        .pop     (tx_pop),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty)
    );

    // TX handshake FSM; li_req is registered so the router never sees a decode glitch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_state <= T_IDLE;
            li_req   <= 1'b0;
            li_data  <= '0;
        end else begin
            tx_state <= tx_next;
            li_req   <= li_req_d;
            if (li_load) li_data <= tx_head;
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (!tx_empty) tx_next = T_SETUP;
            T_SETUP: tx_next = T_REQ;
            T_REQ:   if (ack_s) tx_next = T_REL;
            T_REL:   if (!ack_s) tx_next = T_IDLE;
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        li_load  = (tx_state == T_IDLE) && !tx_empty;
        li_req_d = (tx_next == T_REQ);
        tx_pop   = (tx_state == T_REQ) && ack_s;
    end

    // RX handshake FSM; only src and payload are stored since dst is known to be local
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_state <= R_IDLE;
            lo_ack   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            lo_ack   <= lo_ack_d;
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            R_IDLE:  if (req_s && !rx_full) rx_next = R_ACK;
            R_ACK:   if (!req_s) rx_next = R_IDLE;
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        lo_sample = (rx_state == R_IDLE) && req_s && !rx_full;
        lo_match  = (lo_data[DST_X_HI:DST_X_LO] == X_LOCAL) && (lo_data[DST_Y_HI:DST_Y_LO] == Y_LOCAL);
        rx_push   = lo_sample && lo_match;
        lo_ack_d  = (rx_next == R_ACK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_self  <= 1'b0;
            err_misrt <= 1'b0;
        end else begin
            err_self  <= tx_fire && tx_self;
            err_misrt <= lo_sample && !lo_match;
        end
    end

    noc_sync_fifo #(.W(RX_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (rx_push),
        .wr_data (lo_data[SRC_X_HI:0]),
        .pop     (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty)
    );

    assign rx_valid = !rx_empty;
    assign rx_pop   = rx_valid && rx_ready;

    always_comb begin
        rx_src_x = '0;
        rx_src_y = '0;
        rx_data  = '0;
        if (rx_valid) begin
            rx_src_x = rx_head[SRC_X_HI:SRC_X_LO];
            rx_src_y = rx_head[SRC_Y_HI:SRC_Y_LO];
            rx_data  = rx_head[DATA_HI:DATA_LO];
        end
    end

endmodule

// File: tb/tb_noc_local_ni.sv
// Bench for noc_local_ni: PE-side driver, router-side 4-phase models and a queue-based reference.
`timescale 1ns/1ps
module tb_noc_local_ni;

    localparam logic [3:0] XL = 4'd0;
    localparam logic [3:0] YL = 4'd1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [3:0]  tx_dst_x = '0;
    logic [3:0]  tx_dst_y = '0;
    logic [22:0] tx_data = '0;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic [3:0]  rx_src_x;
    logic [3:0]  rx_src_y;
    logic [22:0] rx_data;
    logic        li_req;
    logic [38:0] li_data;
    logic        li_ack;
    logic        lo_req = 1'b0;
    logic [38:0] lo_data = '0;
    logic        lo_ack;
    logic        err_self;
    logic        err_misrt;

    noc_local_ni #(.WIDTH(39), .X_LOCAL(XL), .Y_LOCAL(YL), .TX_DEPTH(4), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_src_x(rx_src_x), .rx_src_y(rx_src_y), .rx_data(rx_data),
        .li_req(li_req), .li_data(li_data), .li_ack(li_ack),
        .lo_req(lo_req), .lo_data(lo_data), .lo_ack(lo_ack),
        .err_self(err_self), .err_misrt(err_misrt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    logic [38:0] tx_exp[$];
    logic [30:0] rx_exp[$];
    int tx_seen = 0, self_seen = 0, misrt_seen = 0, exp_self = 0, exp_misrt = 0, proto_err = 0;
    int rel_cycles = 0;
    int fixed_dly = 3;
    bit hold_ack = 1'b0, rand_ack = 1'b0, rx_done = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // 4-phase protocol and error-pulse monitor
    logic pl_req = 1'b0, pl_ack = 1'b0, plo_req = 1'b0, plo_ack = 1'b0;
    logic [38:0] pli_data = '0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (li_req && !pl_req && pl_ack) proto_err++;
            if (!li_req && pl_req && !pl_ack) proto_err++;
            if (li_req && pl_req && (li_data !== pli_data)) proto_err++;
            if (lo_ack && !plo_ack && !plo_req) proto_err++;
            if (!lo_ack && plo_ack && plo_req) proto_err++;
        end
        if (err_self === 1'b1) self_seen++;
        if (err_misrt === 1'b1) misrt_seen++;
        pl_req = li_req; pl_ack = li_ack; plo_req = lo_req; plo_ack = lo_ack; pli_data = li_data;
    end

    // Router local_in model: captures each flit, acks after a delay, releases after li_req drops
    initial begin : tx_router
        int cnt;
        int dly;
        logic [38:0] cap;
        logic [38:0] e;
        li_ack = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (rst_n && li_req && !li_ack) begin
                cap = li_data;
                dly = rand_ack ? int'($urandom_range(0, 4)) : fixed_dly;
                cnt = 0;
                while (rst_n && (hold_ack || cnt < dly)) begin @(posedge clk); #1; cnt++; end
                if (rst_n) begin
                    tx_seen++;
                    e = (tx_exp.size() != 0) ? tx_exp.pop_front() : 39'bx;
                    check("tx_flit", 64'(cap), 64'(e));
                    li_ack = 1'b1;
                    cnt = 0;
                    while (rst_n && li_req && cnt < 100) begin @(posedge clk); #1; cnt++; end
                    rel_cycles = cnt;
                    if (rst_n) begin
                        check("li_req_release", 64'(li_req), 64'(1'b0));
                        repeat (rand_ack ? int'($urandom_range(0, 3)) : 1) begin @(posedge clk); #1; end
                    end
                end
                li_ack = 1'b0;
            end
        end
    end

    task automatic send_pkt(input logic [3:0] dx, input logic [3:0] dy, input logic [22:0] d,
                            input int bound, output bit ok);
        int n;
        bit self;
        n = 0;
        self = (dx == XL) && (dy == YL);
        tx_dst_x = dx; tx_dst_y = dy; tx_data = d; tx_valid = 1'b1;
        while (!tx_ready && n < bound) begin @(posedge clk); #1; n++; end
        ok = tx_ready;
        if (ok) begin
            if (self) exp_self++;
            else tx_exp.push_back({dx, dy, XL, YL, d});
            @(posedge clk); #1;
            tx_valid = 1'b0;
            check("err_self_pulse", 64'(err_self), 64'(self));
        end else begin
            tx_valid = 1'b0;
        end
    endtask

    task automatic rx_send(input logic [3:0] dx, input logic [3:0] dy, input logic [3:0] sx,
                           input logic [3:0] sy, input logic [22:0] d, output bit ok);
        int n;
        if (dx == XL && dy == YL) rx_exp.push_back({sx, sy, d});
        else exp_misrt++;
        lo_data = {dx, dy, sx, sy, d};
        lo_req = 1'b1;
        n = 0;
        while (!lo_ack && n < 200) begin @(posedge clk); #1; n++; end
        ok = lo_ack;
        lo_req = 1'b0;
        n = 0;
        while (lo_ack && n < 200) begin @(posedge clk); #1; n++; end
        ok = ok && !lo_ack;
    endtask

    task automatic rx_pop(input string tag, input int bound);
        int n;
        logic [30:0] e;
        n = 0;
        while (!rx_valid && n < bound) begin @(posedge clk); #1; n++; end
        check({tag, "_valid"}, 64'(rx_valid), 64'(1'b1));
        if (rx_valid) begin
            e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 31'bx;
            check(tag, 64'({rx_src_x, rx_src_y, rx_data}), 64'(e));
            rx_ready = 1'b1;
            @(posedge clk); #1;
            rx_ready = 1'b0;
        end
    endtask

    task automatic wait_tx_drain(input int bound);
        int n;
        n = 0;
        while ((tx_exp.size() != 0 || li_req || li_ack) && n < bound) begin @(posedge clk); #1; n++; end
        check("tx_drain", 64'(tx_exp.size()), 64'(0));
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        int n, s0, m0, t0;
        logic [3:0] dx, dy;

        // Reset, then build traffic in both directions and reset again mid-handshake
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        hold_ack = 1'b1;
        send_pkt(4'd2, 4'd3, 23'h111111, 10, ok);
        check("pre_rst_tx0", 64'(ok), 64'(1'b1));
        send_pkt(4'd5, 4'd6, 23'h222222, 10, ok);
        check("pre_rst_tx1", 64'(ok), 64'(1'b1));
        rx_send(XL, YL, 4'd7, 4'd8, 23'h333333, ok);
        check("pre_rst_rx", 64'(ok), 64'(1'b1));
        n = 0;
        while (!li_req && n < 20) begin cyc(1); n++; end
        check("pre_rst_li_req", 64'(li_req), 64'(1'b1));
        check("pre_rst_rx_valid", 64'(rx_valid), 64'(1'b1));
        rst_n = 1'b0;
        cyc(3);
        check("rst_tx_ready", 64'(tx_ready), 64'(1'b0));
        check("rst_rx_valid", 64'(rx_valid), 64'(1'b0));
        check("rst_li_req", 64'(li_req), 64'(1'b0));
        check("rst_lo_ack", 64'(lo_ack), 64'(1'b0));
        check("rst_li_data", 64'(li_data), 64'(0));
        check("rst_errs", 64'({err_self, err_misrt}), 64'(0));
        check("rst_rx_fields", 64'({rx_src_x, rx_src_y, rx_data}), 64'(0));
        tx_exp.delete();
        rx_exp.delete();
        hold_ack = 1'b0;
        rst_n = 1'b1;
        cyc(1);
        check("post_rst_tx_ready", 64'(tx_ready), 64'(1'b1));
        check("post_rst_li_req", 64'(li_req), 64'(1'b0));

        // Single TX flit with a fixed 3-cycle ack
        t0 = tx_seen;
        send_pkt(4'd1, 4'd2, 23'h0ABCDE, 10, ok);
        check("single_accept", 64'(ok), 64'(1'b1));
        n = 0;
        while (!li_req && n < 20) begin cyc(1); n++; end
        check("single_li_data", 64'(li_data), 64'({4'd1, 4'd2, 4'd0, 4'd1, 23'h0ABCDE}));
        wait_tx_drain(100);
        check("single_rel_cycles", 64'(rel_cycles), 64'(3));
        cyc(10);
        check("single_flit_count", 64'(tx_seen - t0), 64'(1));
        check("single_li_req_idle", 64'(li_req), 64'(1'b0));

        // TX backpressure: ack withheld, four packets fill the FIFO
        hold_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_pkt(4'(i + 2), 4'd5, 23'(32'h40000 + i), 10, ok);
            check("bp_accept", 64'(ok), 64'(1'b1));
        end
        cyc(1);
        check("bp_tx_ready_full", 64'(tx_ready), 64'(1'b0));
        cyc(6);
        check("bp_tx_ready_hold", 64'(tx_ready), 64'(1'b0));
        hold_ack = 1'b0;
        send_pkt(4'd9, 4'd9, 23'h4FFFF, 300, ok);
        check("bp_accept_5th", 64'(ok), 64'(1'b1));
        wait_tx_drain(500);

        // RX full: four flits stored, fifth stalls until one pop
        rx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_send(XL, YL, 4'(i), 4'(i + 8), 23'(32'h50000 + i), ok);
            check("rxf_send", 64'(ok), 64'(1'b1));
        end
        rx_exp.push_back({4'd4, 4'd12, 23'h50004});
        lo_data = {XL, YL, 4'd4, 4'd12, 23'h50004};
        lo_req = 1'b1;
        cyc(12);
        check("rxf_backpressure", 64'(lo_ack), 64'(1'b0));
        rx_pop("rxf_pop0", 5);
        n = 0;
        while (!lo_ack && n < 50) begin cyc(1); n++; end
        check("rxf_5th_ack", 64'(lo_ack), 64'(1'b1));
        lo_req = 1'b0;
        n = 0;
        while (lo_ack && n < 50) begin cyc(1); n++; end
        check("rxf_5th_release", 64'(lo_ack), 64'(1'b0));
        for (int i = 0; i < 4; i++) rx_pop("rxf_drain", 5);
        cyc(1);
        check("rxf_empty", 64'(rx_valid), 64'(1'b0));

        // Misrouted RX flit and self-addressed TX packet are dropped
        m0 = misrt_seen;
        rx_send(4'd3, 4'd3, 4'd1, 4'd1, 23'h7ABCD, ok);
        check("misrt_handshake", 64'(ok), 64'(1'b1));
        cyc(5);
        check("misrt_pulse", 64'(misrt_seen - m0), 64'(1));
        check("misrt_rx_valid", 64'(rx_valid), 64'(1'b0));
        t0 = tx_seen;
        s0 = 0;
        send_pkt(XL, YL, 23'h12345, 10, ok);
        check("self_accept", 64'(ok), 64'(1'b1));
        for (int i = 0; i < 10; i++) begin
            if (li_req) s0++;
            cyc(1);
        end
        check("self_no_li_req", 64'(s0), 64'(0));
        check("self_no_flit", 64'(tx_seen - t0), 64'(0));

        // Random soak, 500 packets each way with random handshake and PE delays
        rand_ack = 1'b1;
        rx_done = 1'b0;
        fork
            begin : soak_tx
                bit tok;
                for (int i = 0; i < 500; i++) begin
                    cyc(int'($urandom_range(0, 3)));
                    if ($urandom_range(0, 15) == 0) begin
                        dx = XL; dy = YL;
                    end else begin
                        dx = 4'($urandom_range(0, 15));
                        dy = 4'($urandom_range(0, 15));
                        if (dx == XL && dy == YL) dy = dy + 4'd1;
                    end
                    send_pkt(dx, dy, 23'($urandom), 500, tok);
                    check("soak_tx_accept", 64'(tok), 64'(1'b1));
                end
            end
            begin : soak_rx_drive
                bit rok;
                logic [3:0] rx_x, rx_y;
                for (int i = 0; i < 500; i++) begin
                    cyc(int'($urandom_range(0, 3)));
                    if ($urandom_range(0, 7) != 0) begin
                        rx_x = XL; rx_y = YL;
                    end else begin
                        rx_x = 4'($urandom_range(1, 15));
                        rx_y = 4'($urandom_range(0, 15));
                    end
                    rx_send(rx_x, rx_y, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 23'($urandom), rok);
                    check("soak_rx_handshake", 64'(rok), 64'(1'b1));
                end
                rx_done = 1'b1;
            end
            begin : soak_rx_sink
                int k;
                logic [30:0] e;
                k = 0;
                while (!(rx_done && rx_exp.size() == 0) && k < 40000) begin
                    @(posedge clk); #1; k++;
                    rx_ready = 1'b0;
                    if (rx_valid && ($urandom_range(0, 2) != 0)) begin
                        e = (rx_exp.size() != 0) ? rx_exp.pop_front() : 31'bx;
                        check("soak_rx", 64'({rx_src_x, rx_src_y, rx_data}), 64'(e));
                        rx_ready = 1'b1;
                    end
                end
                @(posedge clk); #1;
                rx_ready = 1'b0;
                check("soak_rx_done", 64'(rx_exp.size()), 64'(0));
            end
        join
        wait_tx_drain(2000);
        cyc(5);
        check("soak_rx_idle", 64'(rx_valid), 64'(1'b0));
        check("err_self_count", 64'(self_seen), 64'(exp_self));
        check("err_misrt_count", 64'(misrt_seen), 64'(exp_misrt));
        check("protocol", 64'(proto_err), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
